// File: rtl/rs_pkg.sv
// Shared definitions for the reservation-station bank: FU select encodings,
// the per-entry record and the cleared-entry value.
package rs_pkg;

  localparam int RS_PRF_IDX_W = 6;
  localparam int RS_ROB_IDX_W = 5;
  localparam int RS_BR_MASK_W = 4;
  localparam int RS_FU_SEL_W  = 3;

  typedef enum logic [RS_FU_SEL_W-1:0] {
    FU_ALU  = 3'd0,
    FU_MUL  = 3'd1,
    FU_BRU  = 3'd2,
    FU_LSU  = 3'd3,
    FU_NONE = 3'd7
  } fu_sel_e;

  localparam logic [RS_FU_SEL_W-1:0] FU_SEL_NONE = 3'd7;

  typedef struct packed {
    logic                    valid;
    logic [RS_PRF_IDX_W-1:0] opa_tag;
    logic                    opa_rdy;
    logic [RS_PRF_IDX_W-1:0] opb_tag;
    logic                    opb_rdy;
    logic [RS_PRF_IDX_W-1:0] dest_tag;
    logic [RS_FU_SEL_W-1:0]  fu_sel;
    logic [31:0]             ir;
    logic [RS_ROB_IDX_W-1:0] rob_idx;
    logic [RS_BR_MASK_W-1:0] br_mask;
  } rs_entry_t;

  localparam int RS_ENTRY_W = $bits(rs_entry_t);

  // A free slot holds zeros except for the "no functional unit" selector.
  function automatic rs_entry_t rs_empty_entry();
    rs_entry_t e;
    e        = '0;
    e.fu_sel = FU_SEL_NONE;
    return e;
  endfunction

endpackage

// File: rtl/rs_bank_chk.sv
// Protocol checker for the branch control inputs of rs_bank.
module rs_bank_chk (
  input logic clk,
  input logic rst,
  input logic i_br_recovery,
  input logic i_br_resolve
);

  br_excl_a: assert property (@(posedge clk) disable iff (rst) !(i_br_recovery && i_br_resolve));

endmodule

// File: rtl/rs_slot.sv
// One reservation-station entry: storage, CDB wakeup (stored and incoming
// tags), branch squash and branch-mask clear on resolve.
module rs_slot
  import rs_pkg::*;
#(
  parameter int CDB_NUM = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_alloc,
  input  logic [RS_ENTRY_W-1:0]          i_wr_entry,
  input  logic                           i_iss_free,
  input  logic [CDB_NUM-1:0]             i_cdb_vld,
  input  logic [CDB_NUM*RS_PRF_IDX_W-1:0] i_cdb_tag,
  input  logic                           i_br_recovery,
  input  logic                           i_br_resolve,
  input  logic [RS_BR_MASK_W-1:0]        i_br_tag_fix,
  output logic [RS_ENTRY_W-1:0]          o_entry,
  output logic                           o_eligible,
  output logic                           o_free
);

  rs_entry_t r_entry;
  rs_entry_t w_next;
  rs_entry_t w_wr;
  logic      w_opa_hit;
  logic      w_opb_hit;
  logic      w_wr_opa_hit;
  logic      w_wr_opb_hit;
  logic      w_squash;

  function automatic logic cdb_hit(input logic [RS_PRF_IDX_W-1:0]         tag,
                                   input logic [CDB_NUM-1:0]              vld,
                                   input logic [CDB_NUM*RS_PRF_IDX_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int c = 0; c < CDB_NUM; c++) begin
      hit = hit | (vld[c] & (tags[c*RS_PRF_IDX_W +: RS_PRF_IDX_W] == tag));
    end
    return hit;
  endfunction

  assign w_wr         = rs_entry_t'(i_wr_entry);
  assign w_opa_hit    = cdb_hit(r_entry.opa_tag, i_cdb_vld, i_cdb_tag);
  assign w_opb_hit    = cdb_hit(r_entry.opb_tag, i_cdb_vld, i_cdb_tag);
  assign w_wr_opa_hit = cdb_hit(w_wr.opa_tag, i_cdb_vld, i_cdb_tag);
  assign w_wr_opb_hit = cdb_hit(w_wr.opb_tag, i_cdb_vld, i_cdb_tag);
  assign w_squash     = r_entry.valid & i_br_recovery & (|(r_entry.br_mask & i_br_tag_fix));

  // Issue and squash in the same cycle collapse into a single free.
  assign o_free     = r_entry.valid & (w_squash | i_iss_free);
  assign o_eligible = r_entry.valid & ~w_squash
                    & (r_entry.opa_rdy | w_opa_hit) & (r_entry.opb_rdy | w_opb_hit);
  assign o_entry    = r_entry;

  // Next-state selection: free, fresh allocation, or in-place wakeup/resolve.
  always_comb begin
    w_next = r_entry;
    if (o_free) begin
      w_next = rs_empty_entry();
    end else if (i_alloc) begin
      w_next         = w_wr;
      w_next.valid   = 1'b1;
      w_next.opa_rdy = w_wr.opa_rdy | w_wr_opa_hit;
      w_next.opb_rdy = w_wr.opb_rdy | w_wr_opb_hit;
      w_next.br_mask = i_br_resolve ? (w_wr.br_mask & ~i_br_tag_fix) : w_wr.br_mask;
    end else if (r_entry.valid) begin
      w_next.opa_rdy = r_entry.opa_rdy | w_opa_hit;
      w_next.opb_rdy = r_entry.opb_rdy | w_opb_hit;
      w_next.br_mask = i_br_resolve ? (r_entry.br_mask & ~i_br_tag_fix) : r_entry.br_mask;
    end else begin
      w_next = r_entry;
    end
  end

  // Entry register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_entry <= rs_empty_entry();
    end else begin
      r_entry <= w_next;
    end
  end

endmodule

// File: rtl/rs_bank.sv
// Multi-entry reservation station: allocates the lowest free slot, wakes
// operands from the CDB and issues the oldest eligible entry via an age matrix.
module rs_bank
  import rs_pkg::*;
#(
  parameter int RS_DEPTH  = 8,
  parameter int CDB_NUM   = 2,
  parameter int PRF_IDX_W = RS_PRF_IDX_W,
  parameter int ROB_IDX_W = RS_ROB_IDX_W,
  parameter int BR_MASK_W = RS_BR_MASK_W,
  parameter int FU_SEL_W  = RS_FU_SEL_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         disp_vld_i,
  input  logic [PRF_IDX_W-1:0]         disp_opa_tag_i,
  input  logic [PRF_IDX_W-1:0]         disp_opb_tag_i,
  input  logic                         disp_opa_rdy_i,
  input  logic                         disp_opb_rdy_i,
  input  logic [PRF_IDX_W-1:0]         disp_dest_tag_i,
  input  logic [FU_SEL_W-1:0]          disp_fu_sel_i,
  input  logic [31:0]                  disp_IR_i,
  input  logic [ROB_IDX_W-1:0]         disp_rob_idx_i,
  input  logic [BR_MASK_W-1:0]         disp_br_mask_i,
  output logic                         disp_rdy_o,
  input  logic [CDB_NUM-1:0]           cdb_vld_i,
  input  logic [CDB_NUM*PRF_IDX_W-1:0] cdb_tag_i,
  output logic                         iss_vld_o,
  input  logic                         iss_rdy_i,
  output logic [PRF_IDX_W-1:0]         iss_opa_tag_o,
  output logic [PRF_IDX_W-1:0]         iss_opb_tag_o,
  output logic [PRF_IDX_W-1:0]         iss_dest_tag_o,
  output logic [FU_SEL_W-1:0]          iss_fu_sel_o,
  output logic [31:0]                  iss_IR_o,
  output logic [ROB_IDX_W-1:0]         iss_rob_idx_o,
  output logic [BR_MASK_W-1:0]         iss_br_mask_o,
  input  logic                         br_recovery_i,
  input  logic                         br_resolve_i,
  input  logic [BR_MASK_W-1:0]         br_tag_fix_i,
  output logic [$clog2(RS_DEPTH):0]    free_cnt_o
);

  localparam int CNT_W = $clog2(RS_DEPTH) + 1;

  logic [RS_ENTRY_W-1:0] w_slot_raw [RS_DEPTH];
  rs_entry_t             w_ent      [RS_DEPTH];
  logic [RS_DEPTH-1:0]   r_age      [RS_DEPTH];
  logic [RS_DEPTH-1:0]   w_valid;
  logic [RS_DEPTH-1:0]   w_elig;
  logic [RS_DEPTH-1:0]   w_slot_free;
  logic [RS_DEPTH-1:0]   w_sel;
  logic [RS_DEPTH-1:0]   w_alloc_oh;
  logic [CNT_W-1:0]      r_free_cnt;
  logic [CNT_W-1:0]      w_cnt_next;
  rs_entry_t             w_disp_ent;
  rs_entry_t             w_iss_ent;
  logic                  w_drop;
  logic                  w_alloc;
  logic                  w_fire;

  assign disp_rdy_o = (r_free_cnt != '0);
  assign w_drop     = br_recovery_i & (|(disp_br_mask_i & br_tag_fix_i));
  assign w_alloc    = disp_vld_i & disp_rdy_o & ~w_drop;
  assign iss_vld_o  = |w_elig;
  assign w_fire     = iss_vld_o & iss_rdy_i;

  // Pack the dispatched instruction into an entry record.
  always_comb begin
    w_disp_ent          = rs_empty_entry();
    w_disp_ent.valid    = 1'b1;
    w_disp_ent.opa_tag  = disp_opa_tag_i;
    w_disp_ent.opa_rdy  = disp_opa_rdy_i;
    w_disp_ent.opb_tag  = disp_opb_tag_i;
    w_disp_ent.opb_rdy  = disp_opb_rdy_i;
    w_disp_ent.dest_tag = disp_dest_tag_i;
    w_disp_ent.fu_sel   = disp_fu_sel_i;
    w_disp_ent.ir       = disp_IR_i;
    w_disp_ent.rob_idx  = disp_rob_idx_i;
    w_disp_ent.br_mask  = disp_br_mask_i;
  end

  // Lowest-index free slot; descending scan so the lowest index wins.
  always_comb begin
    w_alloc_oh = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!w_valid[i]) begin
        w_alloc_oh    = '0;
        w_alloc_oh[i] = 1'b1;
      end else begin
        w_alloc_oh = w_alloc_oh;
      end
    end
  end

  // r_age[i][j] set means entry j is older than entry i.
  for (genvar g = 0; g < RS_DEPTH; g++) begin : g_slot
    rs_slot #(
      .CDB_NUM(CDB_NUM)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .i_alloc      (w_alloc & w_alloc_oh[g]),
      .i_wr_entry   (w_disp_ent),
      .i_iss_free   (w_sel[g] & w_fire),
      .i_cdb_vld    (cdb_vld_i),
      .i_cdb_tag    (cdb_tag_i),
      .i_br_recovery(br_recovery_i),
      .i_br_resolve (br_resolve_i),
      .i_br_tag_fix (br_tag_fix_i),
      .o_entry      (w_slot_raw[g]),
      .o_eligible   (w_elig[g]),
      .o_free       (w_slot_free[g])
    );
    assign w_ent[g]   = rs_entry_t'(w_slot_raw[g]);
    assign w_valid[g] = w_ent[g].valid;
    assign w_sel[g]   = w_elig[g] & ~(|(r_age[g] & w_elig));
  end

  // Output mux over the one-hot oldest-eligible select.
  always_comb begin
    w_iss_ent = rs_empty_entry();
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (w_sel[i]) begin
        w_iss_ent = w_ent[i];
      end else begin
        w_iss_ent = w_iss_ent;
      end
    end
  end

  assign iss_opa_tag_o  = w_iss_ent.opa_tag;
  assign iss_opb_tag_o  = w_iss_ent.opb_tag;
  assign iss_dest_tag_o = w_iss_ent.dest_tag;
  assign iss_fu_sel_o   = w_iss_ent.fu_sel;
  assign iss_IR_o       = w_iss_ent.ir;
  assign iss_rob_idx_o  = w_iss_ent.rob_idx;
  assign iss_br_mask_o  = w_iss_ent.br_mask;

  // Age matrix: new row = currently valid entries, new column cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RS_DEPTH; i++) r_age[i] <= '0;
    end else if (w_alloc) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        r_age[i] <= w_alloc_oh[i] ? w_valid : (r_age[i] & ~w_alloc_oh);
      end
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) r_age[i] <= r_age[i];
    end
  end

  // Next free count: minus the allocation, plus every slot freed this cycle.
  always_comb begin
    w_cnt_next = r_free_cnt - {{(CNT_W-1){1'b0}}, w_alloc};
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_cnt_next = w_cnt_next + {{(CNT_W-1){1'b0}}, w_slot_free[i]};
    end
  end

  // Free-count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_free_cnt <= CNT_W'(RS_DEPTH);
    end else begin
      r_free_cnt <= w_cnt_next;
    end
  end

  assign free_cnt_o = r_free_cnt;

  rs_bank_chk u_chk (
    .clk          (clk),
    .rst          (rst),
    .i_br_recovery(br_recovery_i),
    .i_br_resolve (br_resolve_i)
  );

endmodule

// File: tb/tb_rs_bank.sv
// Bench for rs_bank: directed scenarios plus random traffic, all checked
// against an age-ordered queue model of the reservation station.
module tb_rs_bank;

  localparam int RS_DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        disp_vld_i;
  logic [5:0]  disp_opa_tag_i, disp_opb_tag_i, disp_dest_tag_i;
  logic        disp_opa_rdy_i, disp_opb_rdy_i;
  logic [2:0]  disp_fu_sel_i;
  logic [31:0] disp_IR_i;
  logic [4:0]  disp_rob_idx_i;
  logic [3:0]  disp_br_mask_i;
  logic        disp_rdy_o;
  logic [1:0]  cdb_vld_i;
  logic [11:0] cdb_tag_i;
  logic        iss_vld_o, iss_rdy_i;
  logic [5:0]  iss_opa_tag_o, iss_opb_tag_o, iss_dest_tag_o;
  logic [2:0]  iss_fu_sel_o;
  logic [31:0] iss_IR_o;
  logic [4:0]  iss_rob_idx_o;
  logic [3:0]  iss_br_mask_o;
  logic        br_recovery_i, br_resolve_i;
  logic [3:0]  br_tag_fix_i;
  logic [3:0]  free_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [5:0]  opa, opb, dest;
    logic        ra, rb;
    logic [2:0]  fu;
    logic [31:0] ir;
    logic [4:0]  rob;
    logic [3:0]  mask;
  } m_ent_t;

  m_ent_t q[$];  // valid entries, oldest first

  rs_bank dut (
    .clk(clk), .rst(rst),
    .disp_vld_i(disp_vld_i), .disp_opa_tag_i(disp_opa_tag_i), .disp_opb_tag_i(disp_opb_tag_i),
    .disp_opa_rdy_i(disp_opa_rdy_i), .disp_opb_rdy_i(disp_opb_rdy_i),
    .disp_dest_tag_i(disp_dest_tag_i), .disp_fu_sel_i(disp_fu_sel_i), .disp_IR_i(disp_IR_i),
    .disp_rob_idx_i(disp_rob_idx_i), .disp_br_mask_i(disp_br_mask_i), .disp_rdy_o(disp_rdy_o),
    .cdb_vld_i(cdb_vld_i), .cdb_tag_i(cdb_tag_i),
    .iss_vld_o(iss_vld_o), .iss_rdy_i(iss_rdy_i),
    .iss_opa_tag_o(iss_opa_tag_o), .iss_opb_tag_o(iss_opb_tag_o), .iss_dest_tag_o(iss_dest_tag_o),
    .iss_fu_sel_o(iss_fu_sel_o), .iss_IR_o(iss_IR_o), .iss_rob_idx_o(iss_rob_idx_o),
    .iss_br_mask_o(iss_br_mask_o),
    .br_recovery_i(br_recovery_i), .br_resolve_i(br_resolve_i), .br_tag_fix_i(br_tag_fix_i),
    .free_cnt_o(free_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input logic [5:0] t);
    return (cdb_vld_i[0] && cdb_tag_i[5:0] == t) || (cdb_vld_i[1] && cdb_tag_i[11:6] == t);
  endfunction

  function automatic bit hits_fix(input logic [3:0] m);
    return br_recovery_i && ((m & br_tag_fix_i) != 4'd0);
  endfunction

  // Check outputs against the model for the current inputs, then advance it.
  task automatic model_cycle();
    int     sel = -1;
    bit     fire;
    m_ent_t nq[$];
    m_ent_t e;
    for (int k = 0; k < q.size(); k++) begin
      if (sel < 0 && !hits_fix(q[k].mask) && (q[k].ra || hit(q[k].opa)) && (q[k].rb || hit(q[k].opb)))
        sel = k;
    end
    check_eq("free_cnt", 64'(free_cnt_o), 64'(RS_DEPTH - q.size()));
    check_eq("disp_rdy", 64'(disp_rdy_o), 64'(q.size() < RS_DEPTH));
    check_eq("iss_vld", 64'(iss_vld_o), 64'(sel >= 0));
    if (sel >= 0) begin
      check_eq("iss_IR", 64'(iss_IR_o), 64'(q[sel].ir));
      check_eq("iss_opa", 64'(iss_opa_tag_o), 64'(q[sel].opa));
      check_eq("iss_opb", 64'(iss_opb_tag_o), 64'(q[sel].opb));
      check_eq("iss_dest", 64'(iss_dest_tag_o), 64'(q[sel].dest));
      check_eq("iss_fu", 64'(iss_fu_sel_o), 64'(q[sel].fu));
      check_eq("iss_rob", 64'(iss_rob_idx_o), 64'(q[sel].rob));
      check_eq("iss_mask", 64'(iss_br_mask_o), 64'(q[sel].mask));
    end else begin
      check_eq("idle_fu", 64'(iss_fu_sel_o), 64'd7);
      check_eq("idle_IR", 64'(iss_IR_o), 64'd0);
      check_eq("idle_mask", 64'(iss_br_mask_o), 64'd0);
    end
    fire = (sel >= 0) && iss_rdy_i;
    for (int k = 0; k < q.size(); k++) begin
      if (!((fire && k == sel) || hits_fix(q[k].mask))) begin
        e    = q[k];
        e.ra = e.ra || hit(e.opa);
        e.rb = e.rb || hit(e.opb);
        if (br_resolve_i) e.mask = e.mask & ~br_tag_fix_i;
        nq.push_back(e);
      end
    end
    if (disp_vld_i && q.size() < RS_DEPTH && !hits_fix(disp_br_mask_i)) begin
      e.opa  = disp_opa_tag_i;  e.opb = disp_opb_tag_i;  e.dest = disp_dest_tag_i;
      e.ra   = disp_opa_rdy_i || hit(disp_opa_tag_i);
      e.rb   = disp_opb_rdy_i || hit(disp_opb_tag_i);
      e.fu   = disp_fu_sel_i;  e.ir = disp_IR_i;  e.rob = disp_rob_idx_i;
      e.mask = br_resolve_i ? (disp_br_mask_i & ~br_tag_fix_i) : disp_br_mask_i;
      nq.push_back(e);
    end
    q = nq;
  endtask

  // Called just after a falling edge with inputs driven; returns at the next one.
  task automatic step();
    #1;
    if (rst) q.delete();
    else model_cycle();
    @(negedge clk);
  endtask

  task automatic idle();
    disp_vld_i = 1'b0;  disp_opa_tag_i = 6'd0;  disp_opb_tag_i = 6'd0;  disp_dest_tag_i = 6'd0;
    disp_opa_rdy_i = 1'b0;  disp_opb_rdy_i = 1'b0;  disp_fu_sel_i = 3'd0;  disp_IR_i = 32'd0;
    disp_rob_idx_i = 5'd0;  disp_br_mask_i = 4'd0;  cdb_vld_i = 2'b00;  cdb_tag_i = 12'd0;
    iss_rdy_i = 1'b0;  br_recovery_i = 1'b0;  br_resolve_i = 1'b0;  br_tag_fix_i = 4'd0;
  endtask

  task automatic disp(input logic [5:0] a, input logic ra, input logic [5:0] b, input logic rb,
                      input logic [31:0] ir, input logic [3:0] mask);
    disp_vld_i = 1'b1;  disp_opa_tag_i = a;  disp_opa_rdy_i = ra;  disp_opb_tag_i = b;
    disp_opb_rdy_i = rb;  disp_IR_i = ir;  disp_br_mask_i = mask;
    disp_dest_tag_i = ir[5:0];  disp_fu_sel_i = {1'b0, ir[1:0]};  disp_rob_idx_i = ir[4:0];
  endtask

  task automatic drain();
    idle();
    iss_rdy_i = 1'b1;
    for (int k = 0; k < RS_DEPTH + 1; k++) step();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    #1;
    check_eq("rst_vld", 64'(iss_vld_o), 64'd0);
    check_eq("rst_rdy", 64'(disp_rdy_o), 64'd1);
    check_eq("rst_cnt", 64'(free_cnt_o), 64'd8);
    check_eq("rst_fu", 64'(iss_fu_sel_o), 64'd7);

    // Fill with eight ready instructions, then issue in dispatch order.
    for (int k = 0; k < RS_DEPTH; k++) begin
      idle();
      disp(6'(k), 1'b1, 6'(k + 8), 1'b1, 32'h100 + 32'(k), 4'd0);
      step();
    end
    idle();
    #1;
    check_eq("full_rdy", 64'(disp_rdy_o), 64'd0);
    check_eq("full_cnt", 64'(free_cnt_o), 64'd0);
    iss_rdy_i = 1'b1;
    for (int k = 0; k < RS_DEPTH; k++) begin
      #1;
      check_eq("order", 64'(iss_IR_o), 64'h100 + 64'(k));
      step();
    end
    drain();

    // A waits on tag 12, B ready; CDB port 1 wakes A in cycle 3.
    disp(6'd12, 1'b0, 6'd13, 1'b1, 32'hA, 4'd0);  step();
    idle();  disp(6'd20, 1'b1, 6'd21, 1'b1, 32'hB, 4'd0);  step();
    idle();  cdb_vld_i = 2'b10;  cdb_tag_i = {6'd12, 6'd0};  iss_rdy_i = 1'b1;
    #1;
    check_eq("cdb_vld", 64'(iss_vld_o), 64'd1);
    check_eq("cdb_old", 64'(iss_IR_o), 64'hA);
    step();
    drain();

    // Dispatch-time wakeup from CDB port 0.
    disp(6'd30, 1'b1, 6'd7, 1'b0, 32'hC, 4'd0);  cdb_vld_i = 2'b01;  cdb_tag_i = {6'd0, 6'd7};
    step();
    idle();  iss_rdy_i = 1'b1;
    #1;
    check_eq("dwake_vld", 64'(iss_vld_o), 64'd1);
    check_eq("dwake_IR", 64'(iss_IR_o), 64'hC);
    step();
    drain();

    // Recovery with fix 0010 leaves only the mask-0001 entry.
    disp(6'd1, 1'b1, 6'd2, 1'b1, 32'hD1, 4'b0001);  step();
    idle();  disp(6'd1, 1'b1, 6'd2, 1'b1, 32'hD2, 4'b0010);  step();
    idle();  disp(6'd1, 1'b1, 6'd2, 1'b1, 32'hD3, 4'b0011);  step();
    idle();  br_recovery_i = 1'b1;  br_tag_fix_i = 4'b0010;  step();
    idle();
    #1;
    check_eq("rec_cnt", 64'(free_cnt_o), 64'd7);
    check_eq("rec_IR", 64'(iss_IR_o), 64'hD1);
    drain();

    // Resolve 0001 on a mask-0011 entry.
    disp(6'd3, 1'b1, 6'd4, 1'b1, 32'hE, 4'b0011);  step();
    idle();  br_resolve_i = 1'b1;  br_tag_fix_i = 4'b0001;  step();
    idle();  iss_rdy_i = 1'b1;
    #1;
    check_eq("res_mask", 64'(iss_br_mask_o), 64'b0010);
    step();
    drain();

    // Selected entry squashed while issuing: next-oldest shows, single free.
    disp(6'd5, 1'b1, 6'd6, 1'b1, 32'hF0, 4'b0100);  step();
    idle();  disp(6'd5, 1'b1, 6'd6, 1'b1, 32'hF1, 4'b0000);  step();
    idle();  iss_rdy_i = 1'b1;  br_recovery_i = 1'b1;  br_tag_fix_i = 4'b0100;
    #1;
    check_eq("sq_next", 64'(iss_IR_o), 64'hF1);
    step();
    idle();
    #1;
    check_eq("sq_cnt", 64'(free_cnt_o), 64'd8);
    disp(6'd5, 1'b1, 6'd6, 1'b1, 32'hF2, 4'b0100);  step();
    idle();  iss_rdy_i = 1'b1;  br_recovery_i = 1'b1;  br_tag_fix_i = 4'b0100;
    #1;
    check_eq("sq_none", 64'(iss_vld_o), 64'd0);
    step();
    idle();
    #1;
    check_eq("sq_once", 64'(free_cnt_o), 64'd8);

    // Random traffic, including occasional mid-run reset.
    for (int n = 0; n < 3000; n++) begin
      int r;
      idle();
      if ($urandom_range(0, 9) < 7)
        disp(6'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 6'($urandom_range(0, 15)),
             ($urandom_range(0, 3) == 0), $urandom, 4'($urandom_range(0, 15)));
      cdb_vld_i = 2'($urandom_range(0, 3));
      cdb_tag_i = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
      iss_rdy_i = ($urandom_range(0, 9) < 6);
      r = int'($urandom_range(0, 99));
      br_recovery_i = (r < 4);
      br_resolve_i  = (r >= 4 && r < 10);
      br_tag_fix_i  = 4'b0001 << $urandom_range(0, 3);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
